// File: rtl/ifetch_stage.sv
// ifetch_stage: PC, in-order imem fetch, output FIFO to decode; `MISALIGN_CHK_EN enables misaligned-redirect fault
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_fault
);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  logic [31:0] pc;
  logic [2:0]  outstanding, out_next, discard, count;
  logic [1:0]  wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [31:0] tag_q [4];
  logic [31:0] fifo_pc [4];
  logic [31:0] fifo_instr [4];
  logic [3:0]  in_use;
  logic        fault, grant, drop, push, pop;

  function automatic logic [1:0] inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit covers both in-flight words and buffered entries, so the FIFO can never overflow
  assign in_use      = {1'b0, outstanding} + {1'b0, count};
  assign imem_req    = fetch_en & ~redirect_valid & ~fault & (in_use < {1'b0, DEPTH_C});
  assign imem_addr   = pc;
  assign grant       = imem_req & imem_gnt;
  assign drop        = imem_rvalid & (discard != 3'd0);
  assign push        = imem_rvalid & ~drop & ~redirect_valid;
  assign pop         = id_valid & id_ready & ~redirect_valid;
  assign out_next    = outstanding + {2'b0, grant} - {2'b0, imem_rvalid};
  assign id_valid    = count != 3'd0;
  assign id_pc       = fifo_pc[rd_ptr];
  assign id_instr    = fifo_instr[rd_ptr];
  assign fetch_fault = fault;

  // PC advance, in-flight accounting and old-stream discard count on redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      for (int i = 0; i < 4; i++) tag_q[i] <= '0;
    end else begin
      outstanding <= out_next;
      if (grant) tag_q[tag_wr] <= pc;
      if (grant) tag_wr <= inc(tag_wr);
      if (imem_rvalid) tag_rd <= inc(tag_rd);
      if (redirect_valid) begin
        pc      <= redirect_pc & ~32'd3;
        discard <= out_next;
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (drop) discard <= discard - 3'd1;
      end
    end

  // Output FIFO: responses tagged with their fetch PC, flushed on redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < 4; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= tag_q[tag_rd];
        fifo_instr[wr_ptr] <= imem_rdata;
        wr_ptr             <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + {2'b0, push} - {2'b0, pop};
    end

`ifdef MISALIGN_CHK_EN
  // Sticky fault set by a misaligned redirect, cleared by the next aligned one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fault <= 1'b0;
    else if (redirect_valid) fault <= |redirect_pc[1:0];
`else
  assign fault = 1'b0;
`endif

  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> outstanding != 3'd0);
  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n) outstanding <= DEPTH_C);
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed table, corner sequences and random traffic against a stream-level reference model
module tb_ifetch_stage;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk, rst_n, fetch_en, redirect_valid, imem_req, imem_gnt, imem_rvalid, id_valid, id_ready, fetch_fault;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, id_instr, id_pc;

  ifetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .fetch_fault(fetch_fault)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } resp_t;
  typedef struct { logic [31:0] rpc; logic [31:0] exp_pc; logic exp_fault; } vec_t;

  resp_t resp_q[$];
  vec_t  vecs[4];
  int checks = 0, errors = 0, cyc = 0, last_due = 0, grants = 0, accepts = 0, lat_lo = 1, lat_hi = 1;
  logic [31:0] exp_pc, fpc, prev_addr, prev_id_pc, prev_id_instr, last_grant_addr;
  logic faulted, prev_stall, prev_hold, granted;

  // Memory contents are a fixed scramble of the word address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0F69;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; fetch_en = 0; id_ready = 0; redirect_valid = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    resp_q.delete(); last_due = 0;
    exp_pc = RESET_PC; fpc = RESET_PC; faulted = 0; prev_stall = 0; prev_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_req", imem_req, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  // One cycle: drive inputs and memory, sample outputs, check against the stream model
  task automatic step(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc, input logic g);
    int due;
    @(negedge clk);
    fetch_en = fe; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc; imem_gnt = g;
    imem_rvalid = resp_q.size() > 0 && resp_q[0].due <= cyc;
    imem_rdata = $urandom;
    if (imem_rvalid) begin
      imem_rdata = mem(resp_q[0].addr);
      void'(resp_q.pop_front());
    end
    #1;
    granted = 0;
    chk("fault", fetch_fault, faulted);
    if (rv) chk("req_on_redirect", imem_req, 0);
    if (faulted) begin
      chk("req_faulted", imem_req, 0);
      chk("valid_faulted", id_valid, 0);
    end
    if (prev_stall && fe && !rv) begin
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, prev_addr);
    end
    if (prev_hold) begin
      chk("id_hold_valid", id_valid, 1);
      chk("id_hold_pc", id_pc, prev_id_pc);
      chk("id_hold_instr", id_instr, prev_id_instr);
    end
    if (imem_req && g) begin
      chk("fetch_addr", imem_addr, fpc);
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due < last_due) due = last_due;
      last_due = due;
      resp_q.push_back('{imem_addr, due});
      chk("outstanding_bound", resp_q.size() <= DEPTH, 1);
      last_grant_addr = imem_addr;
      fpc += 4; grants++; granted = 1;
    end
    if (id_valid && rdy && !rv) begin
      chk("id_pc", id_pc, exp_pc);
      chk("id_instr", id_instr, mem(exp_pc));
      exp_pc += 4; accepts++;
    end
    if (rv) begin
`ifdef MISALIGN_CHK_EN
      faulted = |rpc[1:0];
`endif
      exp_pc = {rpc[31:2], 2'b00};
      fpc = exp_pc;
    end
    prev_stall = imem_req && !g && !rv; prev_addr = imem_addr;
    prev_hold = id_valid && !rdy && !rv; prev_id_pc = id_pc; prev_id_instr = id_instr;
    cyc++;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] want);
    int n = 0;
    do begin step(1, 0, 0, 0, 1); n++; end while (!id_valid && n < 60);
    chk({name, "_valid"}, id_valid, 1);
    chk(name, id_pc, want);
  endtask

  initial begin
    int g0, a0, n;
    logic [31:0] rpc;
`ifdef MISALIGN_CHK_EN
    vecs[0] = '{32'h0000_0102, 32'h0, 1'b1};
    vecs[1] = '{32'h0000_0200, 32'h0000_0200, 1'b0};
    vecs[2] = '{32'h8000_0001, 32'h0, 1'b1};
    vecs[3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
`else
    vecs[0] = '{32'h0000_0102, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'h0000_0200, 32'h0000_0200, 1'b0};
    vecs[2] = '{32'h8000_0001, 32'h8000_0000, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0};
`endif
    // Streaming and first-word latency
    do_reset();
    step(1, 1, 0, 0, 1); chk("t1_c0_valid", id_valid, 0); chk("t1_c0_req", imem_req, 1);
    step(1, 1, 0, 0, 1); chk("t1_c1_valid", id_valid, 0);
    step(1, 1, 0, 0, 1); chk("t1_c2_valid", id_valid, 1); chk("t1_c2_pc", id_pc, 0);
    a0 = accepts;
    repeat (20) step(1, 1, 0, 0, 1);
    chk("t1_throughput", accepts - a0 >= 10, 1);
    // Decode stall bounds outstanding work
    do_reset();
    g0 = grants;
    repeat (10) step(1, 0, 0, 0, 1);
    chk("t2_grants", grants - g0 <= DEPTH, 1);
    chk("t2_req", imem_req, 0);
    chk("t2_pc", id_pc, 0);
    a0 = accepts;
    repeat (10) step(1, 1, 0, 0, 1);
    chk("t2_resume", accepts - a0 >= 5, 1);
    // Redirect with two fetches in flight
    do_reset();
    lat_lo = 4; lat_hi = 4;
    step(1, 1, 0, 0, 1); step(1, 1, 0, 0, 1);
    step(1, 1, 1, 32'h100, 1);
    wait_valid("t3_first", 32'h100);
    step(1, 1, 0, 0, 1);
    wait_valid("t3_second", 32'h104);
    // Redirect right after the grant of pc=8
    do_reset();
    lat_lo = 3; lat_hi = 3;
    n = 0;
    do begin step(1, 1, 0, 0, 1); n++; end while (!(granted && last_grant_addr == 32'h8) && n < 40);
    chk("t4_grant8", last_grant_addr, 32'h8);
    step(1, 1, 1, 32'h40, 1);
    wait_valid("t4_redirect", 32'h40);
    // Withheld grant and PC wrap
    do_reset();
    lat_lo = 1; lat_hi = 1;
    step(1, 1, 1, 32'hFFFF_FFFC, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("t5_first", 32'hFFFF_FFFC);
    step(1, 1, 0, 0, 1);
    wait_valid("t5_wrap", 32'h0);
    // Redirect target table
    do_reset();
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, vecs[i].rpc, 1);
      if (vecs[i].exp_fault) begin
        repeat (8) step(1, 1, 0, 0, 1);
        chk("vec_fault_valid", id_valid, 0);
      end else begin
        wait_valid("vec_pc", vecs[i].exp_pc);
        chk("vec_instr", id_instr, mem(vecs[i].exp_pc));
      end
      chk("vec_fault", fetch_fault, vecs[i].exp_fault);
    end
    // Random traffic
    do_reset();
    lat_lo = 1; lat_hi = 4;
    a0 = accepts;
    repeat (3000) begin
      rpc = $urandom;
      if ($urandom_range(3, 0) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(7, 0) != 0, $urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0, rpc,
           $urandom_range(2, 0) != 0);
    end
    chk("rand_progress", accepts - a0 >= 150, 1);
    // Asynchronous reset mid-operation
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_valid", id_valid, 0);
    chk("arst_addr", imem_addr, RESET_PC);
    chk("arst_fault", fetch_fault, 0);
    do_reset();
    lat_lo = 1; lat_hi = 2;
    wait_valid("post_reset", RESET_PC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
